spi_request_arbiter: RTL and testbench

- Shares one SPI_Master engine between NUM_REQ independent requesters, e.g. the PCI register path and the board-config sequencer.
- Arbitrates round-robin and latches the winner's 32-bit command word and chip-select.
- Runs the master's start/done four-phase handshake and returns read data tagged with the requester ID.
- Runs on BOARD_CLOCK. The master's DONE is generated on its divided clock, so the arbiter synchronises it.

---
 rtl/spi_arb_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/spi_request_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_spi_request_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared types and constants for the SPI request arbiter slice.
//   - arb_state_e : transaction FSM states
//   - ID_W        : width of the requester index carried on RESP_ID
//   - cnt_width() : handshake-phase timer width for a given timeout
package spi_arb_pkg;

  localparam int ID_W = 3;

  localparam int TIMEOUT_CYCLES_DEF = 4096;

  // Timer must hold 0..cycles-1; never collapse to a zero-width vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    CAPTURE = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick: the first asserted request at or after
//   ptr, wrapping from NUM_REQ-1 back to 0.
//   req    : request levels
//   ptr    : highest-priority index (always < NUM_REQ)
//   gnt    : one-hot winner (all zero when nothing requests)
//   gnt_id : encoded winner index
//   any    : at least one request is pending
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);

  assign any = |req;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers latches.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Explicit wrap so non-power-of-two NUM_REQ works.
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter
//   Shares one SPI_Master engine between NUM_REQ requesters. A round-robin
//   winner's command word and chip-select are latched, the master's
//   start/done four-phase handshake is run, and the read word is returned
//   tagged with the requester index. Each handshake phase is bounded by
//   TIMEOUT_CYCLES; a stuck DONE in the release phase raises sticky FAULT.
//
//   BOARD_CLOCK / RST_N      : clock, asynchronous active-low reset
//   REQ, REQ_DATA, REQ_SEL   : per-requester level, command word, chip-select
//   GNT                      : one-hot grant, held for the transaction
//   RESP_VALID/ID/DATA/TIMEOUT : one-cycle completion report
//   BUSY, FAULT              : not-idle status, sticky release-phase fault
//   SPI_STAR_O/I_O/SEL_O     : to master start, command, chip-select
//   SPI_DONE_I, SPI_O_I      : from master done (asynchronous), read word
module spi_request_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                   BOARD_CLOCK,
  input  logic                   RST_N,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [32*NUM_REQ-1:0]  REQ_DATA,
  input  logic [2*NUM_REQ-1:0]   REQ_SEL,
  output logic [NUM_REQ-1:0]     GNT,
  output logic                   RESP_VALID,
  output logic [ID_W-1:0]        RESP_ID,
  output logic [31:0]            RESP_DATA,
  output logic                   RESP_TIMEOUT,
  output logic                   BUSY,
  output logic                   FAULT,
  output logic                   SPI_STAR_O,
  output logic [31:0]            SPI_I_O,
  output logic [1:0]             SPI_SEL_O,
  input  logic                   SPI_DONE_I,
  input  logic [31:0]            SPI_O_I
);

  localparam int              TMR_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e             state_q, state_nxt;
  logic [TMR_W-1:0]       tmr_q;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        serve_id;
  logic                   abort_q;
  logic [SYNC_STAGES-1:0] done_sync;
  logic                   done_s;

  logic [NUM_REQ-1:0]     arb_gnt;
  logic [ID_W-1:0]        arb_id;
  logic                   arb_any;

  logic take_grant, do_capture, launch_to, finish, release_to;
  logic [ID_W-1:0]        next_ptr;

  // DONE comes from the master's divided clock domain.
  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      done_sync <= '0;
    end else begin
      done_sync[0] <= SPI_DONE_I;
      for (int i = 1; i < SYNC_STAGES; i++) done_sync[i] <= done_sync[i-1];
    end
  end

  assign done_s = done_sync[SYNC_STAGES-1];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req    (REQ),
    .ptr    (rr_ptr),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt  = state_q;
    take_grant = 1'b0;
    do_capture = 1'b0;
    launch_to  = 1'b0;
    finish     = 1'b0;
    release_to = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          take_grant = 1'b1;
          state_nxt  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (done_s) begin
          state_nxt = CAPTURE;
        end else if (tmr_q == TMR_LAST) begin
          launch_to = 1'b1;
          state_nxt = RELEASE;
        end
      end
      CAPTURE: begin
        do_capture = 1'b1;
        state_nxt  = RELEASE;
      end
      RELEASE: begin
        if (!done_s) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else if (tmr_q == TMR_LAST) begin
          release_to = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One timer shared by both handshake phases: zero on every state entry,
  // saturating at the timeout value.
  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      tmr_q <= '0;
    end else if (state_nxt != state_q || state_q == IDLE) begin
      tmr_q <= '0;
    end else if (tmr_q != TMR_LAST) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign next_ptr = (serve_id == ID_W'(NUM_REQ - 1)) ? '0 : serve_id + 1'b1;

  always_ff @(posedge BOARD_CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      GNT          <= '0;
      RESP_VALID   <= 1'b0;
      RESP_ID      <= '0;
      RESP_DATA    <= '0;
      RESP_TIMEOUT <= 1'b0;
      FAULT        <= 1'b0;
      SPI_I_O      <= '0;
      SPI_SEL_O    <= '0;
      serve_id     <= '0;
      rr_ptr       <= '0;
      abort_q      <= 1'b0;
    end else begin
      RESP_VALID <= 1'b0;
      if (take_grant) begin
        GNT       <= arb_gnt;
        SPI_I_O   <= REQ_DATA[32*int'(arb_id) +: 32];
        SPI_SEL_O <= REQ_SEL[2*int'(arb_id) +: 2];
        serve_id  <= arb_id;
        abort_q   <= 1'b0;
      end
      if (launch_to) abort_q <= 1'b1;
      if (do_capture) RESP_DATA <= SPI_O_I;
      if (finish || release_to) begin
        RESP_VALID   <= 1'b1;
        RESP_ID      <= serve_id;
        RESP_TIMEOUT <= abort_q || release_to;
        // Aborted transactions never report a stale word.
        if (abort_q || release_to) RESP_DATA <= '0;
        GNT    <= '0;
        rr_ptr <= next_ptr;
      end
      if (release_to) FAULT <= 1'b1;
    end
  end

  // Decoded from the state flop, so reset drops start immediately.
  assign SPI_STAR_O = (state_q == LAUNCH) || (state_q == CAPTURE);
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter: a behavioural SPI master,
// a round-robin reference model predicting grants, and a scoreboard that
// compares every completion against the response expected at grant time.
module tb_spi_request_arbiter;
  import spi_arb_pkg::*;

  localparam int N = 3;
  localparam int T = 1024;

  logic                BOARD_CLOCK = 1'b0;
  logic                RST_N;
  logic [N-1:0]        REQ;
  logic [32*N-1:0]     REQ_DATA;
  logic [2*N-1:0]      REQ_SEL;
  logic [N-1:0]        GNT;
  logic                RESP_VALID;
  logic [ID_W-1:0]     RESP_ID;
  logic [31:0]         RESP_DATA;
  logic                RESP_TIMEOUT;
  logic                BUSY;
  logic                FAULT;
  logic                SPI_STAR_O;
  logic [31:0]         SPI_I_O;
  logic [1:0]          SPI_SEL_O;
  logic                SPI_DONE_I;
  logic [31:0]         SPI_O_I;

  always #5 BOARD_CLOCK = ~BOARD_CLOCK;

  spi_request_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .SYNC_STAGES(2)) u_dut (
    .BOARD_CLOCK (BOARD_CLOCK),
    .RST_N       (RST_N),
    .REQ         (REQ),
    .REQ_DATA    (REQ_DATA),
    .REQ_SEL     (REQ_SEL),
    .GNT         (GNT),
    .RESP_VALID  (RESP_VALID),
    .RESP_ID     (RESP_ID),
    .RESP_DATA   (RESP_DATA),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .BUSY        (BUSY),
    .FAULT       (FAULT),
    .SPI_STAR_O  (SPI_STAR_O),
    .SPI_I_O     (SPI_I_O),
    .SPI_SEL_O   (SPI_SEL_O),
    .SPI_DONE_I  (SPI_DONE_I),
    .SPI_O_I     (SPI_O_I)
  );

  typedef enum int {M_NORMAL, M_NEVER, M_STUCK} m_mode_e;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          to;
    bit          chk_data;
    bit          rel_to;
  } exp_t;

  int      n_checks = 0;
  int      n_errors = 0;
  exp_t    exp_q[$];
  int      served_q[$];
  m_mode_e m_mode;
  int      m_delay;
  int      m_rel;
  logic [N-1:0] hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // The emulated SPI slave answers each command with a fixed scramble.
  function automatic logic [31:0] device_word(input logic [31:0] cmd);
    return cmd ^ 32'hDEAD_BE4A;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // ---------------- behavioural SPI master ----------------
  initial begin
    int phase;
    int cnt;
    SPI_DONE_I = 1'b0;
    SPI_O_I    = '0;
    phase      = 0;
    cnt        = 0;
    forever begin
      @(posedge BOARD_CLOCK);
      #1;
      case (phase)
        0: if (SPI_STAR_O) begin cnt = 0; phase = 1; end
        1: begin
          if (!SPI_STAR_O) phase = 0;
          else if (m_mode != M_NEVER) begin
            cnt++;
            if (cnt >= m_delay) begin
              SPI_O_I    = device_word(SPI_I_O);
              SPI_DONE_I = 1'b1;
              phase      = 2;
            end
          end
        end
        2: if (!SPI_STAR_O) begin cnt = 0; phase = 3; end
        default: begin
          if (m_mode != M_STUCK) begin
            if (cnt >= m_rel) begin SPI_DONE_I = 1'b0; phase = 0; end
            cnt++;
          end
        end
      endcase
    end
  end

  // ---------------- reference model + scoreboard monitor ----------------
  bit          model_idle = 1'b1;
  bit          model_fault = 1'b0;
  int          model_ptr = 0;
  bit          pred_valid = 1'b0;
  int          pred_id;
  logic [31:0] pred_data;
  logic [1:0]  pred_sel;
  bit          star_active = 1'b0;
  bit          cur_launch_to = 1'b0;
  int          star_cnt;
  exp_t        e;

  always @(negedge BOARD_CLOCK) begin
    if (!RST_N) begin
      exp_q.delete();
      model_idle  = 1'b1;
      model_fault = 1'b0;
      model_ptr   = 0;
      pred_valid  = 1'b0;
      star_active = 1'b0;
    end else begin
      if (pred_valid) begin
        check("grant_onehot", 32'(GNT), 32'(1 << pred_id));
        check("grant_cmd", SPI_I_O, pred_data);
        check("grant_sel", 32'(SPI_SEL_O), 32'(pred_sel));
        check("grant_star", 32'(SPI_STAR_O), 32'd1);
        e.id       = pred_id;
        e.to       = (m_mode != M_NORMAL);
        e.chk_data = (m_mode != M_STUCK);
        e.data     = (m_mode == M_NORMAL) ? device_word(pred_data) : 32'd0;
        e.rel_to   = (m_mode == M_STUCK);
        exp_q.push_back(e);
        cur_launch_to = (m_mode == M_NEVER);
        star_cnt    = 1;
        star_active = 1'b1;
        model_idle  = 1'b0;
        pred_valid  = 1'b0;
      end else begin
        if (model_idle && GNT != '0) check("spurious_grant", 32'(GNT), 32'd0);
        if (star_active) begin
          if (SPI_STAR_O) star_cnt++;
          else begin
            if (cur_launch_to) check("launch_timeout_len", 32'(star_cnt), 32'(T));
            star_active = 1'b0;
          end
        end
      end
      if (RESP_VALID) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(RESP_VALID), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.rel_to) model_fault = 1'b1;
          check("resp_id", 32'(RESP_ID), 32'(e.id));
          check("resp_timeout", 32'(RESP_TIMEOUT), 32'(e.to));
          if (e.chk_data) check("resp_data", RESP_DATA, e.data);
          check("resp_fault", 32'(FAULT), 32'(model_fault));
          check("resp_gnt_clear", 32'(GNT), 32'd0);
          check("resp_not_busy", 32'(BUSY), 32'd0);
          served_q.push_back(e.id);
          model_ptr = (e.id + 1) % N;
        end
        model_idle  = 1'b1;
        star_active = 1'b0;
      end
      if (model_idle && REQ != '0) begin
        pred_id    = rr_pick(REQ, model_ptr);
        pred_data  = REQ_DATA[32*pred_id +: 32];
        pred_sel   = REQ_SEL[2*pred_id +: 2];
        pred_valid = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // One clock; a requester not marked in hold drops REQ the cycle of its RESP_VALID.
  task automatic tick();
    @(posedge BOARD_CLOCK);
    #1;
    if (RST_N && RESP_VALID && int'(RESP_ID) < N && !hold[RESP_ID]) REQ[RESP_ID] = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int n;
    n = 0;
    tick();
    while (!RESP_VALID && n < budget) begin tick(); n++; end
    if (!RESP_VALID) check("resp_wait_expired", 32'(RESP_VALID), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((REQ != '0 || exp_q.size() != 0 || pred_valid) && n < budget) begin tick(); n++; end
    if (n >= budget) check("drain_expired", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse(input int cycles);
    RST_N = 1'b0;
    repeat (cycles) tick();
    RST_N = 1'b1;
    served_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    RST_N    = 1'b0;
    REQ      = '0;
    REQ_DATA = '0;
    REQ_SEL  = '0;
    hold     = '0;
    m_mode   = M_NORMAL;
    m_delay  = 5;
    m_rel    = 1;
    repeat (3) tick();
    check("rst_gnt", 32'(GNT), 32'd0);
    check("rst_valid", 32'(RESP_VALID), 32'd0);
    check("rst_id", 32'(RESP_ID), 32'd0);
    check("rst_data", RESP_DATA, 32'd0);
    check("rst_timeout", 32'(RESP_TIMEOUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_fault", 32'(FAULT), 32'd0);
    check("rst_star", 32'(SPI_STAR_O), 32'd0);
    check("rst_spi_i", SPI_I_O, 32'd0);
    check("rst_spi_sel", 32'(SPI_SEL_O), 32'd0);
    RST_N = 1'b1;
    tick();

    // Single request, slow master.
    REQ_DATA[31:0] = 32'h0000_00A5;
    REQ_SEL[1:0]   = 2'd1;
    m_delay        = 600;
    REQ            = 3'b001;
    tick();
    check("single_gnt", 32'(GNT), 32'h1);
    check("single_star", 32'(SPI_STAR_O), 32'd1);
    check("single_cmd", SPI_I_O, 32'h0000_00A5);
    check("single_sel", 32'(SPI_SEL_O), 32'd1);
    wait_resp(800);
    check("single_id", 32'(RESP_ID), 32'd0);
    check("single_data", RESP_DATA, 32'hDEAD_BEEF);
    check("single_timeout", 32'(RESP_TIMEOUT), 32'd0);
    drain(50);

    // Reset in the middle of LAUNCH.
    m_delay         = 300;
    REQ_DATA[63:32] = $urandom;
    hold            = 3'b010;
    REQ             = 3'b010;
    repeat (6) tick();
    check("pre_rst_star", 32'(SPI_STAR_O), 32'd1);
    RST_N = 1'b0;
    #1;
    check("async_rst_star", 32'(SPI_STAR_O), 32'd0);
    check("async_rst_gnt", 32'(GNT), 32'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    repeat (3) begin
      tick();
      check("rst_no_valid", 32'(RESP_VALID), 32'd0);
    end
    RST_N   = 1'b1;
    m_delay = 10;
    hold    = '0;
    tick();
    check("post_rst_regrant", 32'(GNT), 32'h2);
    drain(200);

    // Contention from a freshly reset pointer.
    reset_pulse(2);
    for (int i = 0; i < N; i++) begin
      REQ_DATA[32*i +: 32] = $urandom;
      REQ_SEL[2*i +: 2]    = 2'($urandom_range(0, 3));
    end
    m_delay = $urandom_range(3, 20);
    REQ     = 3'b111;
    drain(600);
    check("contend_count", 32'(served_q.size()), 32'd3);
    if (served_q.size() == 3) begin
      check("contend_first", 32'(served_q[0]), 32'd0);
      check("contend_second", 32'(served_q[1]), 32'd1);
      check("contend_third", 32'(served_q[2]), 32'd2);
    end
    served_q.delete();
    REQ = 3'b111;
    drain(600);
    if (served_q.size() > 0) check("contend_wrap", 32'(served_q[0]), 32'd0);
    else check("contend_wrap_count", 32'(served_q.size()), 32'd3);

    // Fairness: requester 0 holds, requester 2 arrives mid-transaction.
    served_q.delete();
    m_delay = 20;
    hold    = 3'b001;
    REQ     = 3'b001;
    begin
      int n;
      n = 0;
      while (!GNT[0] && n < 50) begin tick(); n++; end
      check("fair_gnt0", 32'(GNT[0]), 32'd1);
      repeat (3) tick();
      REQ[2] = 1'b1;
      n = 0;
      while (served_q.size() < 2 && n < 400) begin tick(); n++; end
    end
    hold = '0;
    drain(400);
    check("fair_count", 32'(served_q.size()), 32'd3);
    if (served_q.size() == 3) begin
      check("fair_first", 32'(served_q[0]), 32'd0);
      check("fair_second", 32'(served_q[1]), 32'd2);
      check("fair_third", 32'(served_q[2]), 32'd0);
    end

    // Randomised traffic against the model.
    for (int it = 0; it < 40; it++) begin
      m_delay = $urandom_range(1, 40);
      m_rel   = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) begin
        if (!REQ[i] && $urandom_range(0, 1) == 1) begin
          REQ_DATA[32*i +: 32] = $urandom;
          REQ_SEL[2*i +: 2]    = 2'($urandom_range(0, 3));
          REQ[i]               = 1'b1;
        end
      end
      repeat ($urandom_range(1, 30)) tick();
    end
    drain(3000);

    // LAUNCH-phase timeout: master never answers.
    m_mode           = M_NEVER;
    REQ_DATA[95:64]  = $urandom;
    REQ              = 3'b100;
    wait_resp(T + 50);
    check("lto_id", 32'(RESP_ID), 32'd2);
    check("lto_timeout", 32'(RESP_TIMEOUT), 32'd1);
    check("lto_data", RESP_DATA, 32'd0);
    check("lto_fault", 32'(FAULT), 32'd0);
    drain(50);
    m_mode = M_NORMAL;

    // RELEASE-phase timeout: DONE stuck high.
    m_delay = 8;
    m_mode  = M_STUCK;
    REQ     = 3'b010;
    wait_resp(T + 100);
    check("rto_id", 32'(RESP_ID), 32'd1);
    check("rto_timeout", 32'(RESP_TIMEOUT), 32'd1);
    check("rto_fault", 32'(FAULT), 32'd1);
    drain(50);
    m_mode = M_NORMAL;
    m_rel  = 2;
    repeat (10) tick();
    REQ_DATA[31:0] = $urandom;
    REQ            = 3'b001;
    wait_resp(200);
    check("after_fault_timeout", 32'(RESP_TIMEOUT), 32'd0);
    check("after_fault_data", RESP_DATA, device_word(REQ_DATA[31:0]));
    check("fault_sticky", 32'(FAULT), 32'd1);
    drain(50);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
